// File: rtl/dtb_pkg.sv
// Shared types and geometry for the trace buffer memory: word/address widths,
// the FSM state encoding and the modulo pointer increment.
package dtb_pkg;

  localparam int TRB_WIDTH      = 32;
  localparam int TRB_ADDR_WIDTH = 4;
  localparam int TRB_DEPTH      = 2 ** TRB_ADDR_WIDTH;

  typedef logic [TRB_ADDR_WIDTH-1:0] trb_addr_t;
  typedef logic [TRB_WIDTH-1:0]      trb_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } mem_state_t;

  // Pointers have no carry bit, so the increment wraps at TRB_DEPTH.
  function automatic trb_addr_t ptr_inc(input trb_addr_t ptr);
    return ptr + TRB_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/trb_ram.sv
// Single-port trace storage: synchronous write, registered synchronous read.
// The read register resets to zero; the array itself holds no reset.
module trb_ram
  import dtb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  logic      re_i,
  input  trb_addr_t addr_i,
  input  trb_word_t wdata_i,
  output trb_word_t rdata_o
);

  trb_word_t mem_q [TRB_DEPTH];
  trb_word_t rdata_q;

  // NOTE: the array has no reset branch so it maps onto RAM macros; contents
  // are initialised by the clear sweep instead.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_buffer_mem.sv
// Trace buffer memory controller: post-reset clear sweep, alternating write/read
// turns and registered full/empty flags. Clear sweep built only with TRB_MEM_CLEAR_EN.
module trace_buffer_mem
  import dtb_pkg::*;
#(
  parameter logic [TRB_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      CLK_I,
  input  logic                      RST_NI,
  input  logic                      CLEAR_I,
  output logic                      BUSY_O,
  output logic                      RW_TURN_O,
  input  logic                      WRITE_I,
  output logic                      WRITE_ALLOW_O,
  output logic                      READ_ALLOW_O,
  input  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_I,
  input  logic [TRB_WIDTH-1:0]      DMEM_I,
  input  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_I,
  output logic [TRB_WIDTH-1:0]      DMEM_O,
  output logic                      WRITE_DROP_O
);

  mem_state_t state_q, state_d;
  logic       busy_q, busy_d;
  logic       rw_turn_q, rw_turn_d;
  logic       write_allow_q, write_allow_d;
  logic       read_allow_q, read_allow_d;
  logic       write_drop_q, write_drop_d;

  logic       run;
  logic       wr_turn;
  logic       wr_fire;
  logic       wr_drop;
  logic       rd_fire;
  logic       clr_fire;

  trb_addr_t  ram_addr;
  trb_word_t  ram_wdata;
  logic       ram_we;

`ifdef TRB_MEM_CLEAR_EN
  localparam trb_addr_t LAST_ADDR = TRB_ADDR_WIDTH'(TRB_DEPTH - 1);

  trb_addr_t  clr_addr_q, clr_addr_d;
  logic       clear_entry;
`else
  // CLEAR_I and INIT_VALUE have no function without the sweep.
  logic unused_ok;
  assign unused_ok = &{1'b0, CLEAR_I, INIT_VALUE};
`endif

  // Turn and flag decode from registered state only.
  assign run     = (state_q == ST_RUN);
  assign wr_turn = run && rw_turn_q;
  assign wr_fire = wr_turn && WRITE_I && write_allow_q;
  assign wr_drop = wr_turn && WRITE_I && !write_allow_q;
  assign rd_fire = run && !rw_turn_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef TRB_MEM_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_RUN;
`endif
      end
`ifdef TRB_MEM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (CLEAR_I) begin
          state_d = ST_CLEAR;
        end
      end
`else
      ST_RUN: state_d = ST_RUN;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TRB_MEM_CLEAR_EN
  assign clr_fire     = (state_q == ST_CLEAR);
  assign clear_entry  = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  assign clr_addr_d   = clr_fire ? clr_addr_q + TRB_ADDR_WIDTH'(1) : '0;
  assign write_drop_d = clear_entry ? 1'b0 : (write_drop_q | wr_drop);
`else
  assign clr_fire     = 1'b0;
  assign write_drop_d = write_drop_q | wr_drop;
`endif

  // Outputs are registered against the next state so they align with state_q.
  assign busy_d        = (state_d != ST_RUN);
  assign rw_turn_d     = (state_d == ST_RUN) && (run ? !rw_turn_q : 1'b1);
  assign write_allow_d = (state_d == ST_RUN) && (ptr_inc(WRITE_PTR_I) != READ_PTR_I);
  assign read_allow_d  = (state_d == ST_RUN) && (READ_PTR_I != WRITE_PTR_I);

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b1;
      rw_turn_q     <= 1'b0;
      write_allow_q <= 1'b0;
      read_allow_q  <= 1'b0;
      write_drop_q  <= 1'b0;
`ifdef TRB_MEM_CLEAR_EN
      clr_addr_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q       <= state_d;
      busy_q        <= busy_d;
      rw_turn_q     <= rw_turn_d;
      write_allow_q <= write_allow_d;
      read_allow_q  <= read_allow_d;
      write_drop_q  <= write_drop_d;
`ifdef TRB_MEM_CLEAR_EN
      clr_addr_q    <= clr_addr_d;
`endif
    end
  end

  // Single RAM port: sweep owns it during CLEAR, otherwise the turn selects the pointer.
`ifdef TRB_MEM_CLEAR_EN
  assign ram_addr  = clr_fire ? clr_addr_q : (rw_turn_q ? WRITE_PTR_I : READ_PTR_I);
  assign ram_wdata = clr_fire ? INIT_VALUE : DMEM_I;
`else
  assign ram_addr  = rw_turn_q ? WRITE_PTR_I : READ_PTR_I;
  assign ram_wdata = DMEM_I;
`endif
  assign ram_we    = wr_fire | clr_fire;

  trb_ram u_ram (
    .clk_i   (CLK_I),
    .rst_ni  (RST_NI),
    .we_i    (ram_we),
    .re_i    (rd_fire),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (DMEM_O)
  );

  assign BUSY_O        = busy_q;
  assign RW_TURN_O     = rw_turn_q;
  assign WRITE_ALLOW_O = write_allow_q;
  assign READ_ALLOW_O  = read_allow_q;
  assign WRITE_DROP_O  = write_drop_q;

endmodule

// File: tb/tb_trace_buffer_mem.sv
// Directed bench for trace_buffer_mem; expectations adapt to whether
// TRB_MEM_CLEAR_EN is defined for the build.
module tb_trace_buffer_mem;

  localparam logic [31:0] INIT = 32'hA5A5_5A5A;
`ifdef TRB_MEM_CLEAR_EN
  localparam int EXP_BOOT_BUSY = 17;
`else
  localparam int EXP_BOOT_BUSY = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic        write_i;
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic [31:0] din;
  logic        busy;
  logic        rw_turn;
  logic        wallow;
  logic        rallow;
  logic [31:0] dout;
  logic        drop;

  int checks   = 0;
  int failures = 0;

  trace_buffer_mem #(.INIT_VALUE(INIT)) dut (
    .CLK_I         (clk),
    .RST_NI        (rst_n),
    .CLEAR_I       (clear_i),
    .BUSY_O        (busy),
    .RW_TURN_O     (rw_turn),
    .WRITE_I       (write_i),
    .WRITE_ALLOW_O (wallow),
    .READ_ALLOW_O  (rallow),
    .WRITE_PTR_I   (wptr),
    .DMEM_I        (din),
    .READ_PTR_I    (rptr),
    .DMEM_O        (dout),
    .WRITE_DROP_O  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with BUSY_O high, bounded so a stuck sweep cannot hang the run.
  task automatic count_busy(output int n, input int pulse_at);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == pulse_at) clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] wp, input logic [3:0] rp, input logic [31:0] data);
    wptr = wp;
    rptr = rp;
    din  = data;
    tick();
    tick();
    if (rw_turn !== 1'b1) tick();
    write_i = 1'b1;
    tick();
    write_i = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] rp, output logic [31:0] data);
    rptr = rp;
    if (rw_turn === 1'b1) tick();
    tick();
    data = dout;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'b0, busy},    32'd1);
    check({tag, "_rwturn"}, {31'b0, rw_turn}, 32'd0);
    check({tag, "_wallow"}, {31'b0, wallow},  32'd0);
    check({tag, "_rallow"}, {31'b0, rallow},  32'd0);
    check({tag, "_dout"},   dout,             32'd0);
    check({tag, "_drop"},   {31'b0, drop},    32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          n;

    rst_n   = 1'b0;
    clear_i = 1'b0;
    write_i = 1'b0;
    wptr    = '0;
    rptr    = '0;
    din     = '0;

    repeat (3) tick();
    check_reset_outputs("rst");

    rst_n = 1'b1;
    count_busy(n, 0);
    check("boot_busy_cycles", n, EXP_BOOT_BUSY);
    check("first_run_turn", {31'b0, rw_turn}, 32'd1);
    tick();
    check("turn_toggle_rd", {31'b0, rw_turn}, 32'd0);
    tick();
    check("turn_toggle_wr", {31'b0, rw_turn}, 32'd1);

`ifdef TRB_MEM_CLEAR_EN
    do_read(4'd9, rd);
    check("boot_init_a9", rd, INIT);
    do_read(4'd15, rd);
    check("boot_init_a15", rd, INIT);
`endif

    // Basic write/read and hold on the following write turn.
    do_write(4'd3, 4'd0, 32'hDEAD_BEEF);
    do_write(4'd6, 4'd0, 32'h600D_F00D);
    do_read(4'd3, rd);
    check("rd_a3", rd, 32'hDEAD_BEEF);
    rptr = 4'd6;
    tick();
    check("dout_hold", dout, 32'hDEAD_BEEF);
    check("no_drop_yet", {31'b0, drop}, 32'd0);

    // WRITE_I on a read turn is ignored and never flags a drop.
    wptr = 4'd6;
    rptr = 4'd0;
    din  = 32'hBAD0_0BAD;
    if (rw_turn === 1'b1) tick();
    write_i = 1'b1;
    tick();
    write_i = 1'b0;
    check("rdturn_write_nodrop", {31'b0, drop}, 32'd0);
    do_read(4'd6, rd);
    check("rdturn_write_ignored", rd, 32'h600D_F00D);

    // Full: write pointer one behind read pointer.
    do_write(4'd4, 4'd0, 32'h4444_4444);
    wptr = 4'd4;
    rptr = 4'd5;
    tick();
    check("full_wallow", {31'b0, wallow}, 32'd0);
    check("full_rallow", {31'b0, rallow}, 32'd1);
    if (rw_turn !== 1'b1) tick();
    din     = 32'hBADB_AD00;
    write_i = 1'b1;
    tick();
    write_i = 1'b0;
    check("full_drop", {31'b0, drop}, 32'd1);
    do_read(4'd4, rd);
    check("full_mem_kept", rd, 32'h4444_4444);

    // Empty and wrap boundaries.
    wptr = 4'd15;
    rptr = 4'd15;
    tick();
    check("empty_rallow", {31'b0, rallow}, 32'd0);
    check("empty_wallow", {31'b0, wallow}, 32'd1);
    wptr = 4'd0;
    tick();
    check("wrap_rallow", {31'b0, rallow}, 32'd1);
    check("wrap_wallow", {31'b0, wallow}, 32'd1);
    wptr = 4'd15;
    rptr = 4'd0;
    tick();
    check("wrap_full_wallow", {31'b0, wallow}, 32'd0);
    check("wrap_full_rallow", {31'b0, rallow}, 32'd1);
    check("drop_sticky", {31'b0, drop}, 32'd1);

    // Clear request from RUN.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
`ifdef TRB_MEM_CLEAR_EN
    check("clr_busy", {31'b0, busy}, 32'd1);
    check("clr_drop_cleared", {31'b0, drop}, 32'd0);
    count_busy(n, 5);
    check("clr_busy_cycles", n, 32'd16);
    check("clr_first_run_turn", {31'b0, rw_turn}, 32'd1);
    do_read(4'd3, rd);
    check("clr_init_a3", rd, INIT);
    do_read(4'd4, rd);
    check("clr_init_a4", rd, INIT);

    // Reset in the middle of a sweep, at sweep address 7.
    do_write(4'd12, 4'd0, 32'h1212_1212);
    do_read(4'd12, rd);
    check("pre_sweep_a12", rd, 32'h1212_1212);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsweep_rst");
    tick();
    rst_n = 1'b1;
    count_busy(n, 0);
    check("resweep_busy_cycles", n, 32'd17);
    do_read(4'd12, rd);
    check("resweep_init_a12", rd, INIT);
    do_read(4'd0, rd);
    check("resweep_init_a0", rd, INIT);
`else
    check("noclr_busy", {31'b0, busy}, 32'd0);
    check("noclr_drop_kept", {31'b0, drop}, 32'd1);
    do_read(4'd3, rd);
    check("noclr_a3_kept", rd, 32'hDEAD_BEEF);

    // Reset during RUN with non-zero outputs.
    wptr = 4'd2;
    rptr = 4'd0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("run_rst");
    tick();
    rst_n = 1'b1;
    count_busy(n, 0);
    check("reboot_busy_cycles", n, 32'd1);
    check("reboot_first_turn", {31'b0, rw_turn}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_buffer_mem.md
TRACE_BUFFER_MEM -- requirements
Module: trace_buffer_mem

Interface
REQ-001 Parameter INIT_VALUE, default '0 (TRB_WIDTH bits), word written to every location during a clear sweep.
REQ-002 Port CLK_I  input  1  system clock; single clock domain.
REQ-003 Port RST_NI  input  1  reset; asynchronous, active-low.
REQ-004 Port CLEAR_I  input  1  synchronous request to re-run the clear sweep.
REQ-005 Port BUSY_O  output  1  high while the clear sweep runs.
REQ-006 Port RW_TURN_O  output  1  turn strobe; 1 = write turn, 0 = read turn.
REQ-007 Port WRITE_I  input  1  write intent from the logger.
REQ-008 Port WRITE_ALLOW_O  output  1  buffer not full.
REQ-009 Port READ_ALLOW_O  output  1  buffer not empty.
REQ-010 Port WRITE_PTR_I  input  TRB_ADDR_WIDTH  write address.
REQ-011 Port DMEM_I  input  TRB_WIDTH  write data.
REQ-012 Port READ_PTR_I  input  TRB_ADDR_WIDTH  read address.
REQ-013 Port DMEM_O  output  TRB_WIDTH  registered read data.
REQ-014 Port WRITE_DROP_O  output  1  sticky flag; a requested write was discarded.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (the reset state), CLEAR and RUN.
REQ-016 IDLE SHALL go to CLEAR on the first clock after reset release (RUN if the REQ-031 macro is absent).
REQ-017 CLEAR SHALL write INIT_VALUE to addresses 0..TRB_DEPTH-1, one address per cycle, using an internal TRB_ADDR_WIDTH counter, for exactly TRB_DEPTH cycles.
REQ-018 CLEAR SHALL go to RUN in the cycle after address TRB_DEPTH-1 is written.
REQ-019 While in IDLE or CLEAR: BUSY_O=1, RW_TURN_O=0, WRITE_ALLOW_O=0 and READ_ALLOW_O=0.
REQ-020 CLEAR_I SHALL be ignored during CLEAR; in RUN it SHALL enter CLEAR next cycle with the counter at 0.
REQ-021 In RUN, RW_TURN_O SHALL start at 1 in the first RUN cycle and toggle every cycle.
REQ-022 WRITE_ALLOW_O SHALL be registered: 1 iff ((WRITE_PTR_I+1) mod TRB_DEPTH) != READ_PTR_I, sampled the previous cycle.
REQ-023 READ_ALLOW_O SHALL be registered: 1 iff READ_PTR_I != WRITE_PTR_I, sampled the previous cycle.
REQ-024 Pointer arithmetic SHALL wrap modulo TRB_DEPTH, with no carry bit, so usable capacity is TRB_DEPTH-1 words.
REQ-025 A write SHALL occur iff RUN, RW_TURN_O=1, WRITE_I=1 and WRITE_ALLOW_O=1: mem[WRITE_PTR_I] <= DMEM_I at that edge.
REQ-026 WRITE_I=1 with WRITE_ALLOW_O=0 during a write turn SHALL discard the data and set WRITE_DROP_O. WRITE_I during a read turn SHALL be ignored without setting the flag.
REQ-027 On a read turn in RUN, DMEM_O SHALL load mem[READ_PTR_I] at the next edge (1-cycle latency) and hold at all other times.
REQ-028 Reads and writes use disjoint turns, so no same-address collision exists and no bypass is required.
REQ-029 WRITE_DROP_O SHALL clear only on reset or on entry to CLEAR.

Reset
REQ-030 Asserting RST_NI, including mid-sweep, SHALL immediately force: state IDLE, counter 0, RW_TURN_O=0, WRITE_ALLOW_O=0, READ_ALLOW_O=0, BUSY_O=1, DMEM_O='0 and WRITE_DROP_O=0. Memory contents are not reset.

Configuration
REQ-031 Macro TRB_MEM_CLEAR_EN defined: the CLEAR state, counter and CLEAR_I are compiled in.
REQ-032 Macro TRB_MEM_CLEAR_EN absent: IDLE goes straight to RUN, CLEAR_I is unconnected internally, BUSY_O is low after the first post-reset cycle, and INIT_VALUE is unused.

Structure
REQ-033 The DTB_PKG package SHALL define TRB_WIDTH, TRB_ADDR_WIDTH, TRB_DEPTH (= 2**TRB_ADDR_WIDTH) and the FSM state typedef mem_state_t.
REQ-034 Storage SHALL live in one sub-module, trb_ram: single-port, synchronous read, write-enable, address mux driven by this block.

Verification (bench: TRB_ADDR_WIDTH=4, TRB_WIDTH=32, macro defined)
REQ-035 Reset release: BUSY_O=1 for 17 cycles (IDLE + 16 CLEAR); RW_TURN_O=1 in the first RUN cycle; a read of any address returns INIT_VALUE.
REQ-036 WRITE_PTR_I=3, DMEM_I=32'hDEADBEEF, WRITE_I=1 on a write turn, then READ_PTR_I=3 on the next read turn: DMEM_O=32'hDEADBEEF one cycle later.
REQ-037 READ_PTR_I=5, WRITE_PTR_I=4 (full): WRITE_ALLOW_O=0 next cycle; WRITE_I on a write turn leaves mem[4] unchanged and sets WRITE_DROP_O=1.
REQ-038 READ_PTR_I=WRITE_PTR_I=15: READ_ALLOW_O=0. Then WRITE_PTR_I=0 (wrap): READ_ALLOW_O=1 and WRITE_ALLOW_O=1.
REQ-039 CLEAR_I=1 in RUN with WRITE_DROP_O=1: BUSY_O=1 for 16 cycles, WRITE_DROP_O=0, mem[3]=INIT_VALUE. A second CLEAR_I mid-sweep does not extend the sweep.
REQ-040 RST_NI low at sweep address 7: all outputs at reset values immediately; after release, a full 16-cycle sweep restarts at address 0.
